// File: rtl/ncc_pkg.sv
// Shared types and constants for the NCC peak finder.
package ncc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } peak_state_t;

  typedef logic signed [31:0] score_t;

  localparam score_t SCORE_MIN = 32'sh8000_0000;

endpackage

// File: rtl/raster_counter.sv
// Raster-order (x,y) position counter for the search window.
// x wraps at numCols-1 and carries into y; the compare-based wrap keeps
// power-of-two sizes and single-row/column windows from overflowing.
module raster_counter #(
  parameter int unsigned numCols = 64,
  parameter int unsigned numRows = 64,
  localparam int unsigned XW = (numCols > 1) ? $clog2(numCols) : 1,
  localparam int unsigned YW = (numRows > 1) ? $clog2(numRows) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          advance,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          last
);

  localparam logic [XW-1:0] XMAX = XW'(numCols - 1);
  localparam logic [YW-1:0] YMAX = YW'(numRows - 1);

  logic x_end;
  logic y_end;

  // End-of-row / end-of-window decode
  always_comb begin
    x_end = (x == XMAX);
    y_end = (y == YMAX);
    last  = x_end && y_end;
  end

  // Position registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (x_end) begin
        x <= '0;
        y <= y_end ? '0 : y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

endmodule

// File: rtl/ncc_peak_finder.sv
// NCC peak finder: scans a raster-ordered score stream and reports the
// strictly-greatest score with its (x,y), earliest position winning ties.
// Optional runner-up tracking is enabled by defining NCC_PEAK_RUNNER_UP_EN.
module ncc_peak_finder
  import ncc_pkg::*;
#(
  parameter int unsigned scoreW  = 32,
  parameter int unsigned numCols = 64,
  parameter int unsigned numRows = 64,
  localparam int unsigned XW = (numCols > 1) ? $clog2(numCols) : 1,
  localparam int unsigned YW = (numRows > 1) ? $clog2(numRows) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              scoreValid,
  output logic              scoreReady,
  input  logic [scoreW-1:0] score,
  output logic              peakValid,
  input  logic              peakReady,
  output logic [scoreW-1:0] peakScore,
  output logic [XW-1:0]     peakX,
  output logic [YW-1:0]     peakY,
`ifdef NCC_PEAK_RUNNER_UP_EN
  output logic [scoreW-1:0] secondScore,
`endif
  output logic              busy
);

  peak_state_t state, state_d;

  logic          xfer;
  logic          first;
  logic          gt_best;
  logic [XW-1:0] cnt_x;
  logic [YW-1:0] cnt_y;
  logic          cnt_last;

  assign xfer    = scoreValid && scoreReady;
  assign gt_best = $signed(score) > $signed(peakScore);

  raster_counter #(
    .numCols (numCols),
    .numRows (numRows)
  ) u_raster_counter (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == IDLE),
    .advance (xfer),
    .x       (cnt_x),
    .y       (cnt_y),
    .last    (cnt_last)
  );

  // Next-state logic
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    if (xfer && cnt_last) state_d = DONE;
      DONE:    if (peakReady) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  // Handshake/status outputs registered from the next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scoreReady <= 1'b0;
      peakValid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      scoreReady <= (state_d == SCAN);
      peakValid  <= (state_d == DONE);
      busy       <= (state_d != IDLE);
    end
  end

  // First-score flag: armed in IDLE, consumed by the first transfer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              first <= 1'b1;
    else if (state == IDLE) first <= 1'b1;
    else if (xfer)         first <= 1'b0;
  end

  // Best score and its position; only a strictly greater score replaces it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      peakScore <= '0;
      peakX     <= '0;
      peakY     <= '0;
    end else if (xfer && (first || gt_best)) begin
      peakScore <= score;
      peakX     <= cnt_x;
      peakY     <= cnt_y;
    end
  end

`ifdef NCC_PEAK_RUNNER_UP_EN
  logic gt_second;
  assign gt_second = $signed(score) > $signed(secondScore);

  // Runner-up: demoted best on a new max, else any score above it.
  // Most-negative value of scoreW bits (SCORE_MIN at 32 bits) on start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      secondScore <= '0;
    end else if (state == IDLE && start) begin
      secondScore <= {1'b1, {(scoreW-1){1'b0}}};
    end else if (xfer && !first) begin
      if (gt_best)        secondScore <= peakScore;
      else if (gt_second) secondScore <= score;
    end
  end
`endif

endmodule

// File: tb/tb_ncc_peak_finder.sv
// Directed self-checking bench for ncc_peak_finder (4x3 search window).
module tb_ncc_peak_finder;

  localparam int unsigned COLS = 4;
  localparam int unsigned ROWS = 3;
  localparam int unsigned N    = COLS * ROWS;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        scoreValid = 1'b0;
  logic        peakReady = 1'b0;
  logic [31:0] score = '0;
  logic        scoreReady;
  logic        peakValid;
  logic        busy;
  logic [31:0] peakScore;
  logic [1:0]  peakX;
  logic [1:0]  peakY;
`ifdef NCC_PEAK_RUNNER_UP_EN
  logic [31:0] secondScore;
`endif

  int total = 0;
  int bad   = 0;

  logic [31:0] vec [N];

  ncc_peak_finder #(
    .scoreW  (32),
    .numCols (COLS),
    .numRows (ROWS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .scoreValid  (scoreValid),
    .scoreReady  (scoreReady),
    .score       (score),
    .peakValid   (peakValid),
    .peakReady   (peakReady),
    .peakScore   (peakScore),
    .peakX       (peakX),
    .peakY       (peakY),
`ifdef NCC_PEAK_RUNNER_UP_EN
    .secondScore (secondScore),
`endif
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Pulse start with a junk score offered in the same cycle (must be ignored)
  task automatic do_start;
    start      = 1'b1;
    scoreValid = 1'b1;
    score      = 32'h7fff_ffff;
    tick();
    start      = 1'b0;
    scoreValid = 1'b0;
    check("ready_after_start", scoreReady, 1);
    check("busy_after_start", busy, 1);
  endtask

  // Stream vec[] with optional random gaps; optional start pulse mid-scan
  task automatic feed(input int max_gap, input bit start_mid);
    for (int i = 0; i < N; i++) begin
      int g;
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      scoreValid = 1'b0;
      repeat (g) tick();
      start      = (start_mid && i == 5);
      scoreValid = 1'b1;
      score      = vec[i];
      tick();
      start = 1'b0;
      if (i < N - 1) check("no_early_valid", peakValid, 0);
      else           check("valid_after_last", peakValid, 1);
    end
    scoreValid = 1'b0;
  endtask

  task automatic handshake;
    peakReady = 1'b1;
    tick();
    peakReady = 1'b0;
    check("valid_drop", peakValid, 0);
    check("idle_busy", busy, 0);
    check("idle_ready", scoreReady, 0);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_ready", scoreReady, 0);
    check("rst_valid", peakValid, 0);
    check("rst_busy", busy, 0);
    check("rst_score", peakScore, 0);
    check("rst_x", 32'(peakX), 0);
    check("rst_y", 32'(peakY), 0);
`ifdef NCC_PEAK_RUNNER_UP_EN
    check("rst_second", secondScore, 0);
`endif
    rst = 1'b1;
    tick();
    check("idle_ready0", scoreReady, 0);

    // Unique maximum 100 at index 6 -> (2,1); back-to-back scores
    for (int i = 0; i < N; i++) vec[i] = 32'(i);
    vec[6] = 32'd100;
    do_start();
    feed(0, 1'b0);
    check("u_score", peakScore, 100);
    check("u_x", 32'(peakX), 2);
    check("u_y", 32'(peakY), 1);
    check("u_done_ready", scoreReady, 0);
`ifdef NCC_PEAK_RUNNER_UP_EN
    check("u_second", secondScore, 11);
`endif
    handshake();

    // Ties, all negative -> earliest position
    for (int i = 0; i < N; i++) vec[i] = 32'hffff_fffb;
    tick();
    do_start();
    feed(0, 1'b0);
    check("t_score", peakScore, 32'hffff_fffb);
    check("t_x", 32'(peakX), 0);
    check("t_y", 32'(peakY), 0);
`ifdef NCC_PEAK_RUNNER_UP_EN
    check("t_second", secondScore, 32'hffff_fffb);
`endif
    handshake();

    // Gaps, then consumer backpressure in DONE
    vec = '{32'd5, 32'hffff_fffe, 32'd7, 32'd7, 32'd1, 32'd0,
            32'd3, 32'd6, 32'd7, 32'd2, 32'hffff_fff7, 32'd4};
    tick();
    do_start();
    feed(3, 1'b0);
    for (int c = 0; c < 10; c++) begin
      scoreValid = 1'b1;
      score      = 32'd1000;
      start      = (c == 3);
      tick();
      start = 1'b0;
      check("bp_valid", peakValid, 1);
      check("bp_ready", scoreReady, 0);
      check("bp_score", peakScore, 7);
      check("bp_x", 32'(peakX), 2);
      check("bp_y", 32'(peakY), 0);
    end
    scoreValid = 1'b0;
`ifdef NCC_PEAK_RUNNER_UP_EN
    check("bp_second", secondScore, 7);
`endif
    handshake();
    tick();
    check("bp_still_idle", busy, 0);

    // Abort mid-search by reset, then a clean full search
    do_start();
    scoreValid = 1'b1;
    score      = 32'd500;
    repeat (5) tick();
    scoreValid = 1'b0;
    rst = 1'b0;
    #1;
    check("ab_valid", peakValid, 0);
    check("ab_busy", busy, 0);
    check("ab_ready", scoreReady, 0);
    check("ab_score", peakScore, 0);
    tick();
    rst = 1'b1;
    tick();
    check("ab_idle_valid", peakValid, 0);
    for (int i = 0; i < N; i++) vec[i] = 32'd0;
    vec[11] = 32'd7;
    do_start();
    feed(0, 1'b0);
    check("ab_res_score", peakScore, 7);
    check("ab_res_x", 32'(peakX), 3);
    check("ab_res_y", 32'(peakY), 2);
    handshake();

    // Runner-up pattern, with a start pulse ignored during SCAN
    for (int i = 0; i < N; i++) vec[i] = 32'd0;
    vec[0] = 32'd3;
    vec[1] = 32'd9;
    vec[2] = 32'd4;
    vec[3] = 32'd8;
    tick();
    do_start();
    feed(0, 1'b1);
    check("r_score", peakScore, 9);
    check("r_x", 32'(peakX), 1);
    check("r_y", 32'(peakY), 0);
`ifdef NCC_PEAK_RUNNER_UP_EN
    check("r_second", secondScore, 8);
`endif
    handshake();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ncc_peak_finder.md
# ncc_peak_finder

Downstream stage of the normalized cross-correlation engine: consumes the raster-ordered stream of signed NCC scores (one per candidate offset in the search window) and reports the best-scoring position. One search is armed per `start` pulse; the result is held behind a valid/ready handshake until the tracking controller takes it.

## Interface
- `scoreW`, 32: signed score width, two's complement.
- `numCols`, 64: search positions per row (x range).
- `numRows`, 64: search rows (y range).

- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: reset, asynchronous, active-low; all state cleared while low.
- `start` in 1: single-cycle pulse that arms a new search; honoured only in IDLE.
- `scoreValid` in 1: `score` present.
- `scoreReady` out 1: block accepts a score this cycle.
- `score` in scoreW: signed NCC score for the next raster position.
- `peakValid` out 1: result registers hold a completed search.
- `peakReady` in 1: consumer takes the result.
- `peakScore` out scoreW: maximum score.
- `peakX` out $clog2(numCols): column of the maximum.
- `peakY` out $clog2(numRows): row of the maximum.
- `busy` out 1: high in SCAN and DONE.
- `secondScore` out scoreW: runner-up score. Present only with `NCC_PEAK_RUNNER_UP_EN`.

## Operation
- FSM states are IDLE, SCAN and DONE.
- IDLE:
  - `start` -> SCAN.
  - x/y counters are cleared to 0.
  - The first-score flag is set.
- SCAN:
  - `scoreReady` = 1.
  - A transfer occurs when `scoreValid && scoreReady`.
  - On each transfer the score is tagged with the current (x,y).
  - x increments; when x = numCols-1 it wraps to 0 and y increments.
  - The transfer at (numCols-1, numRows-1) -> DONE.
- Best tracking:
  - The first transfer loads best unconditionally.
  - Later transfers replace best only when signed `score > best` (strict).
  - Ties keep the earliest position in raster order.
- DONE:
  - `peakValid` = 1 and the outputs are stable.
  - `peakValid && peakReady` -> IDLE.
- Boundary rules:
  - `start` in SCAN or DONE is ignored.
  - `scoreValid` in IDLE or DONE is not accepted (`scoreReady` = 0).
  - `start` and `scoreValid` in the same IDLE cycle: only `start` acts. The first score is accepted next cycle at the earliest.
  - A `rst` assertion mid-search aborts it immediately. No partial result is emitted.
  - numCols = 1 or numRows = 1 must work. The counters must not overflow when numCols or numRows is a power of two.

## Timing
- Reset values:
  - state = IDLE.
  - `scoreReady`, `peakValid`, `busy` = 0.
  - `peakScore`, `peakX`, `peakY`, `secondScore` = 0.
- `scoreReady` is a registered function of state. It rises the cycle after `start`.
- Throughput is one score per cycle with no bubbles.
- `peakValid` rises the cycle after the final transfer. Minimum search = numCols*numRows + 2 cycles from `start`.
- Results update only on transfers and never change while `peakValid` = 1.
- `peakValid` drops the cycle after the handshake.
- A new `start` is honoured at the earliest in the cycle after the return to IDLE.

## Configuration
- `NCC_PEAK_RUNNER_UP_EN` defined:
  - A runner-up register is added and the `secondScore` port is present.
  - Runner-up is initialised to `SCORE_MIN` on `start`.
  - On a transfer where `score > best`: runner-up takes the old best and best takes `score`.
  - On a transfer where `score <= best` and `score > runner-up`: runner-up takes `score`.
  - The first transfer leaves runner-up at `SCORE_MIN`.
- `NCC_PEAK_RUNNER_UP_EN` undefined: no runner-up register and no `secondScore` port. All other behaviour is identical.

## Structure
- Package `ncc_pkg` holds:
  - `peak_state_t` enum {IDLE, SCAN, DONE}.
  - `score_t` typedef (signed [31:0]).
  - `SCORE_MIN` constant (most negative 32-bit value).
- Sub-module `raster_counter`:
  - Parameters numCols and numRows.
  - Inputs `clk`, `rst`, `clear`, `advance`.
  - Outputs x, y and `last`, where `last` = (x = numCols-1 && y = numRows-1).
- The top level holds the FSM, the compare and the result registers.

## Test plan
Bench parameters: numCols = 4, numRows = 3 (12 scores).
- Reset value check: drive `rst` low with no `start` -> all outputs 0 and state IDLE.
- Unique maximum: scores 0..11 with 100 at index 6 -> `peakScore` = 100, `peakX` = 2, `peakY` = 1. `peakValid` rises exactly 1 cycle after the 12th transfer.
- Ties and all-negative: all scores = -5 -> `peakScore` = -5, (0,0). With `NCC_PEAK_RUNNER_UP_EN`: `secondScore` = -5.
- Backpressure and gaps: random `scoreValid` gaps, then hold `peakReady` = 0 for 10 cycles -> outputs stable, `scoreReady` = 0 in DONE, IDLE one cycle after the handshake.
- Abort: assert `rst` low after 5 transfers, release, then run a full search with max 7 at (3,2) -> no stale `peakValid`; result is 7 at (3,2).
- Runner-up (macro on): scores 3, 9, 4, 8, rest 0 -> `peakScore` = 9, `secondScore` = 8. A second `start` issued during SCAN has no effect.
